// File: rtl/spell_debug_host.sv
// spell_debug_host: debug command host driving the Spell core's serial load/dump/run pins.
// Define SPELL_DEBUG_HOST_WAIT_EN to make RUN/STEP wait for tgt_stop with a TIMEOUT_W-bit timeout.
module spell_debug_host #(
  parameter int TIMEOUT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_timeout,
  output logic [6:0] tgt_ui,
  input  logic       tgt_shift_out,
  input  logic       tgt_stop
);
  typedef enum logic [3:0] {
    S_IDLE, S_SHIFT, S_LOAD, S_DUMP, S_GAP, S_CAPTURE, S_RUN, S_WAIT_STOP, S_DONE
  } state_t;
  state_t     r_state, w_state;
  logic [7:0] r_data, w_data, r_rdata, w_rdata;
  logic [3:0] r_cnt, w_cnt;
  logic [1:0] r_reg, w_reg, w_sel;
  logic [4:0] w_lo;
  logic [6:0] r_ui;
  logic       r_ready, w_ready, r_valid, w_valid;
`ifdef SPELL_DEBUG_HOST_WAIT_EN
  logic [TIMEOUT_W-1:0] r_tmr, w_tmr;
  logic                 r_tout, w_tout;
  assign rsp_timeout = r_tout;
`else
  logic w_unused;
  assign w_unused    = tgt_stop ^ (TIMEOUT_W == 0);
  assign rsp_timeout = 1'b0;
`endif
  assign cmd_ready = r_ready;
  assign rsp_valid = r_valid;
  assign rsp_data  = r_rdata;
  assign tgt_ui    = r_ui;
  // Every output is computed from the next state and registered, so pins change on the edge.
  always_comb begin
    w_state = r_state;
    w_data  = r_data;
    w_cnt   = r_cnt;
    w_reg   = r_reg;
    w_sel   = r_reg;
    w_lo    = '0;
    w_ready = 1'b0;
    w_valid = 1'b0;
    w_rdata = '0;
`ifdef SPELL_DEBUG_HOST_WAIT_EN
    w_tmr   = r_tmr;
    w_tout  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_sel   = 2'd0;
        w_ready = 1'b1;
        if (cmd_valid && r_ready) begin
          w_ready = 1'b0;
          w_reg   = cmd_reg;
          w_sel   = cmd_reg;
          w_data  = cmd_data;
          w_cnt   = '0;
          w_state = cmd_op == 2'd0 ? S_SHIFT : cmd_op == 2'd1 ? S_DUMP : S_RUN;
          w_lo    = cmd_op == 2'd0 ? {cmd_data[7], 4'b0} :
                    cmd_op == 2'd1 ? 5'b01000 : {3'b0, cmd_op[0], 1'b1};
        end
      end
      S_SHIFT: begin
        w_data = {r_data[6:0], 1'b0};
        if (r_cnt == 4'd7) begin
          w_state = S_LOAD;
          w_lo    = 5'b00100;
        end else begin
          w_cnt = r_cnt + 4'd1;
          w_lo  = {r_data[6], 4'b0};
        end
      end
      S_LOAD: begin
        w_state = S_DONE;
        w_valid = 1'b1;
      end
      S_DUMP: w_state = S_GAP;
      S_GAP: begin
        w_state = S_CAPTURE;
        w_cnt   = '0;
      end
      S_CAPTURE: begin
        w_data = {r_data[6:0], tgt_shift_out};
        if (r_cnt == 4'd7) begin
          w_state = S_DONE;
          w_valid = 1'b1;
          w_rdata = w_data;
        end else w_cnt = r_cnt + 4'd1;
      end
`ifdef SPELL_DEBUG_HOST_WAIT_EN
      S_RUN: begin
        w_state = S_WAIT_STOP;
        w_tmr   = TIMEOUT_W'(1);
      end
      // Timer starts at 1 so all-ones marks the last allowed wait cycle.
      S_WAIT_STOP: begin
        if (tgt_stop || &r_tmr) begin
          w_state = S_DONE;
          w_valid = 1'b1;
          w_tout  = ~tgt_stop;
        end else w_tmr = r_tmr + TIMEOUT_W'(1);
      end
`else
      S_RUN: begin
        w_state = S_DONE;
        w_valid = 1'b1;
      end
`endif
      S_DONE: begin
        w_state = S_IDLE;
        w_sel   = 2'd0;
        w_ready = 1'b1;
      end
      default: begin
        w_state = S_IDLE;
        w_sel   = 2'd0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_reg   <= '0;
      r_ui    <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_rdata <= '0;
`ifdef SPELL_DEBUG_HOST_WAIT_EN
      r_tmr   <= '0;
      r_tout  <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_data  <= w_data;
      r_cnt   <= w_cnt;
      r_reg   <= w_reg;
      r_ui    <= {w_sel, w_lo};
      r_ready <= w_ready;
      r_valid <= w_valid;
      r_rdata <= w_rdata;
`ifdef SPELL_DEBUG_HOST_WAIT_EN
      r_tmr   <= w_tmr;
      r_tout  <= w_tout;
`endif
    end
  end
endmodule

// File: tb/tb_spell_debug_host.sv
// tb_spell_debug_host: vector table, random commands and reset/backpressure corner cases
// against a behavioural Spell core and an independent register-file expectation model.
module tb_spell_debug_host;
  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, tgt_shift_out = 1'b0, tgt_stop = 1'b0;
  logic [1:0] cmd_op = '0, cmd_reg = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, rsp_valid, rsp_timeout;
  logic [7:0] rsp_data;
  logic [6:0] tgt_ui;
  int checks = 0, failures = 0;
`ifdef SPELL_DEBUG_HOST_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif
  always #5 clk = ~clk;
  spell_debug_host #(.TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_reg(cmd_reg), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .tgt_ui(tgt_ui), .tgt_shift_out(tgt_shift_out), .tgt_stop(tgt_stop)
  );
  // Core state (driven only by pin activity) and expected state (driven only by issued commands).
  logic [7:0] c_r[0:3], c_stk[0:255], e_r[0:3], e_stk[0:255];
  logic [7:0] c_sh = '0, d_byte = '0;
  int d_ph = -1;
  function automatic logic [7:0] c_rd(input logic [1:0] s);
    return s == 2'd3 ? c_stk[8'(c_r[1] - 8'd1)] : c_r[s];
  endfunction
  function automatic logic [7:0] e_rd(input logic [1:0] s);
    return s == 2'd3 ? e_stk[8'(e_r[1] - 8'd1)] : e_r[s];
  endfunction
  task automatic c_wr(input logic [1:0] s, input logic [7:0] v);
    if (s == 2'd3) c_stk[8'(c_r[1] - 8'd1)] = v; else c_r[s] = v;
  endtask
  task automatic e_wr(input logic [1:0] s, input logic [7:0] v);
    if (s == 2'd3) e_stk[8'(e_r[1] - 8'd1)] = v; else e_r[s] = v;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // One clock: the core reacts to the pins it saw during the cycle that just ended.
  task automatic tick();
    logic [6:0] u;
    u = tgt_ui;
    @(posedge clk);
    #1;
    if (u[2]) c_wr(u[6:5], c_sh); else c_sh = {c_sh[6:0], u[4]};
    if (u[3]) begin
      d_byte = c_rd(u[6:5]);
      d_ph   = 0;
    end else if (d_ph >= 0 && d_ph < 9) d_ph++;
    else d_ph = -1;
    tgt_shift_out = (d_ph >= 1 && d_ph <= 8) ? d_byte[3'(8 - d_ph)] : 1'($urandom);
  endtask
  function automatic logic [6:0] exp_ui(input logic [1:0] op, input logic [1:0] rg,
                                        input logic [7:0] d, input int n);
    logic [4:0] lo;
    lo = '0;
    if (op == 2'd0 && n >= 1 && n <= 8) lo[4] = d[3'(8 - n)];
    if (op == 2'd0 && n == 9) lo[2] = 1'b1;
    if (op == 2'd1 && n == 1) lo[3] = 1'b1;
    if (op >= 2'd2 && n == 1) lo[1:0] = {op[0], 1'b1};
    return {rg, lo};
  endfunction
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] rg, input logic [7:0] d,
                        input bit hold, input int exp_lat, input logic [7:0] exp_rd, input bit exp_to);
    int n, bad;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = rg; cmd_data = d;
    tick();
    if (!hold) begin
      cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_reg = 2'($urandom); cmd_data = 8'($urandom);
    end
    n = 1; bad = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      if (tgt_ui !== exp_ui(op, rg, d, n) || cmd_ready !== 1'b0) bad++;
      tick(); n++;
    end
    if (tgt_ui !== {rg, 5'b0} || cmd_ready !== 1'b0) bad++;
    chk("ui_trace", bad, 0);
    chk("latency", n, exp_lat);
    chk("rsp_data", rsp_data, exp_rd);
    chk("rsp_timeout", rsp_timeout, exp_to);
    tick();
    cmd_valid = 1'b0;
    chk("ready_after_done", cmd_ready, 1);
    chk("valid_one_cycle", rsp_valid, 0);
    chk("ui_idle", tgt_ui, 0);
  endtask
  task automatic post_load(input logic [1:0] rg, input logic [7:0] d);
    e_wr(rg, d);
    chk("core_reg", c_rd(rg), d);
  endtask
  typedef struct {
    logic [1:0] op;
    logic [1:0] rg;
    logic [7:0] d;
    logic [7:0] rd;
    int         lat;
  } vec_t;
  vec_t tbl[14];
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] op, rg;
    logic [7:0] d, rd, pc0;
    logic st;
    int lat, n, bad, rl;
    for (int i = 0; i < 256; i++) begin c_stk[i] = 8'(i * 7); e_stk[i] = 8'(i * 7); end
    for (int i = 0; i < 4; i++) begin c_r[i] = '0; e_r[i] = '0; end
    rl = WAIT ? 3 : 2;
    tbl[0]  = '{2'd0, 2'd0, 8'hA5, 8'h00, 10};
    tbl[1]  = '{2'd1, 2'd0, 8'h00, 8'hA5, 11};
    tbl[2]  = '{2'd0, 2'd1, 8'h03, 8'h00, 10};
    tbl[3]  = '{2'd0, 2'd3, 8'h3C, 8'h00, 10};
    tbl[4]  = '{2'd1, 2'd3, 8'h00, 8'h3C, 11};
    tbl[5]  = '{2'd1, 2'd1, 8'h00, 8'h03, 11};
    tbl[6]  = '{2'd0, 2'd2, 8'h5A, 8'h00, 10};
    tbl[7]  = '{2'd1, 2'd2, 8'h00, 8'h5A, 11};
    tbl[8]  = '{2'd3, 2'd0, 8'h00, 8'h00, rl};
    tbl[9]  = '{2'd2, 2'd2, 8'h00, 8'h00, rl};
    tbl[10] = '{2'd0, 2'd0, 8'hFF, 8'h00, 10};
    tbl[11] = '{2'd1, 2'd0, 8'h00, 8'hFF, 11};
    tbl[12] = '{2'd0, 2'd0, 8'h00, 8'h00, 10};
    tbl[13] = '{2'd1, 2'd0, 8'h00, 8'h00, 11};
    tick(); tick();
    chk("reset_ui", tgt_ui, 0);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_rdata", rsp_data, 0);
    chk("reset_timeout", rsp_timeout, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_reset", cmd_ready, 1);
    tgt_stop = 1'b1;
    foreach (tbl[i]) begin
      do_cmd(tbl[i].op, tbl[i].rg, tbl[i].d, 1'b0, tbl[i].lat, tbl[i].rd, 1'b0);
      if (tbl[i].op == 2'd0) post_load(tbl[i].rg, tbl[i].d);
    end
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3)); rg = 2'($urandom); d = 8'($urandom); st = 1'($urandom);
      tgt_stop = st;
      lat = op == 2'd0 ? 10 : op == 2'd1 ? 11 : !WAIT ? 2 : st ? 3 : 17;
      rd  = op == 2'd1 ? e_rd(rg) : 8'h00;
      do_cmd(op, rg, d, 1'b0, lat, rd, WAIT && op >= 2'd2 && !st);
      if (op == 2'd0) post_load(rg, d);
    end
    tgt_stop = 1'b0;
    do_cmd(2'd2, 2'd1, 8'h00, 1'b0, WAIT ? 17 : 2, 8'h00, WAIT);
    do_cmd(2'd1, 2'd0, 8'h00, 1'b1, 11, e_rd(2'd0), 1'b0);
    pc0 = c_rd(2'd0);
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_reg = 2'd0; cmd_data = ~pc0;
    tick();
    cmd_valid = 1'b0;
    bad = 0;
    for (int k = 1; k < 5; k++) begin
      if (tgt_ui !== exp_ui(2'd0, 2'd0, ~pc0, k)) bad++;
      tick();
    end
    chk("pre_reset_trace", bad, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_ui_now", tgt_ui, 0);
    chk("rst_valid_now", rsp_valid, 0);
    bad = 0;
    repeat (3) begin
      tick();
      if (tgt_ui !== 7'd0 || rsp_valid !== 1'b0) bad++;
    end
    rst = 1'b0;
    tick();
    chk("ready_after_abort", cmd_ready, 1);
    repeat (10) begin
      if (rsp_valid !== 1'b0 || tgt_ui !== 7'd0) bad++;
      tick();
    end
    chk("abort_quiet", bad, 0);
    chk("abort_no_load", c_rd(2'd0), pc0);
    do_cmd(2'd1, 2'd0, 8'h00, 1'b0, 11, e_rd(2'd0), 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spell_debug_host.md
SPELL_DEBUG_HOST -- requirements
Module: spell_debug_host

Interface
REQ-001 Parameter TIMEOUT_W, default 16: width of the stop-wait timeout counter.
REQ-002 clk  input  1  single clock, shared with the Spell core.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  host idle; command accepted on a clock edge where cmd_valid=1 and cmd_ready=1.
REQ-006 cmd_op  input  2  0=LOAD, 1=DUMP, 2=RUN, 3=STEP.
REQ-007 cmd_reg  input  2  target register select: 0=PC, 1=SP, 2=EXEC, 3=STACK_TOP.
REQ-008 cmd_data  input  8  LOAD payload.
REQ-009 rsp_valid  output  1  one-cycle completion pulse, no backpressure.
REQ-010 rsp_data  output  8  DUMP result; 0 for all other ops.
REQ-011 rsp_timeout  output  1  qualified by rsp_valid; stop-wait expired.
REQ-012 tgt_ui  output  7  drives core ui_in[6:0]: [0]=run, [1]=step, [2]=load, [3]=dump, [4]=shift_in, [6:5]=reg_sel.
REQ-013 tgt_shift_out  input  1  core uo_out[3].
REQ-014 tgt_stop  input  1  core uo_out[1], high in Stop or Sleep.

Function
REQ-015 All outputs SHALL be registered; cmd_ready=1 only in IDLE.
REQ-016 FSM states: IDLE, SHIFT, LOAD, DUMP, GAP, CAPTURE, RUN, WAIT_STOP, DONE.
REQ-017 On accept, cmd_op, cmd_reg and cmd_data SHALL be latched; tgt_ui[6:5]=latched reg from cycle 1 through DONE; cycle n = n-th cycle after the accept edge.
REQ-018 LOAD: SHIFT drives tgt_ui[4]=data[7] in cycle 1 down to data[0] in cycle 8 (MSB first); LOAD drives tgt_ui[2]=1 in cycle 9 only; DONE in cycle 10.
REQ-019 DUMP: tgt_ui[3]=1 in cycle 1 only; GAP in cycle 2; CAPTURE samples tgt_shift_out at the ends of cycles 3..10 as bits 7..0; DONE in cycle 11 with rsp_data = the captured byte.
REQ-020 RUN/STEP: tgt_ui[0]=1 in cycle 1 only; tgt_ui[1]=1 in cycle 1 for STEP, 0 for RUN; tgt_ui[0]=0 from cycle 2 onward.
REQ-021 Outside the cycles stated above, tgt_ui[4:0]=0.
REQ-022 DONE lasts exactly one cycle with rsp_valid=1, then IDLE; cmd_ready=1 in the cycle after DONE at the earliest.
REQ-023 A 4-bit bit counter SHALL count 0..7 in SHIFT and CAPTURE, with no wrap beyond 7.
REQ-024 cmd_valid while busy SHALL be ignored; there is no queuing.

Reset
REQ-025 rst asserted SHALL immediately force IDLE, tgt_ui=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, counters=0, and cmd_ready=1 from the first edge after release.
REQ-026 rst asserted mid-command SHALL abort the command with no rsp_valid; a partial LOAD SHALL never emit a load pulse.

Configuration
REQ-027 Macro SPELL_DEBUG_HOST_WAIT_EN.
REQ-028 Defined: after RUN, enter WAIT_STOP from cycle 2; go to DONE on the first edge with tgt_stop=1 (rsp_timeout=0); after 2^TIMEOUT_W-1 cycles without stop, go to DONE with rsp_timeout=1.
REQ-029 Undefined: RUN goes straight to DONE in cycle 2; rsp_timeout is tied to 0; no timeout counter is synthesized.

Verification
REQ-030 LOAD reg=0 data=0xA5 -> tgt_ui[4] shows 1,0,1,0,0,1,0,1 over cycles 1-8; tgt_ui[2]=1 in cycle 9; rsp_valid in cycle 10; core PC=0xA5.
REQ-031 With core SP=3 and stack[2]=0x3C, DUMP reg=3 -> rsp_valid in cycle 11 with rsp_data=0x3C.
REQ-032 STEP with core stopped -> tgt_ui[1:0]=2'b11 in cycle 1 only. With WAIT_EN: rsp_valid once tgt_stop rises, rsp_timeout=0. Without WAIT_EN: rsp_valid in cycle 2.
REQ-033 WAIT_EN, TIMEOUT_W=4, RUN with tgt_stop held 0 -> rsp_valid with rsp_timeout=1 after 15 wait cycles.
REQ-034 rst pulsed in cycle 5 of LOAD -> tgt_ui=0 immediately, no load pulse, no rsp_valid, cmd_ready=1 after release.
REQ-035 cmd_valid held high through a DUMP -> exactly one command executed, next accept no earlier than the cycle after DONE.
